regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (MEM/WB) and a long-latency unit (LLU: multiplier/divider) that retires out of band. LLU results are buffered in a small FIFO and written in cycles the pipeline leaves idle. A starvation guard briefly freezes writeback so buffered results cannot wait forever. The block drives the regfile write port through a registered write stage, and exports a pending-destination mask to decode for hazard detection.

Parameters:
DEPTH, 4, LLU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles of a non-empty FIFO before a forced grant (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
wb_valid  in  1  pipeline writeback request; held stable while wb_stall=1
wb_rd  in  5  pipeline destination register
wb_data  in  32  pipeline write data
wb_stall  out  1  freeze request to the pipeline (MEM/WB and upstream hold)
llu_valid  in  1  LLU result valid
llu_rd  in  5  LLU destination register
llu_data  in  32  LLU result
llu_ready  out  1  FIFO can accept (=!full, from registered count)
rf_we  out  1  regfile write enable (registered)
rf_rd  out  5  regfile write address (registered)
rf_wdata  out  32  regfile write data (registered)
pending_mask  out  32  bit r=1 if r is the destination of a valid FIFO entry or of the current write stage
fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, state IDLE, counter 0. All outputs 0, except llu_ready=1.
- Accept rules: wb accepted = wb_valid && !wb_stall. LLU push = llu_valid && llu_ready.
- LLU with llu_rd=0: handshake completes; nothing is stored.
- Pipeline write with wb_rd=0: accepted; rf_we stays 0.
- Write stage latency:
  - Accepted pipeline write appears on rf_* the next cycle.
  - FIFO has no fall-through: an entry pushed in cycle t can pop at t+1 at the earliest, so it reaches rf_* at t+2.
- Grant per cycle, in priority order:
  1. State FORCE: pop FIFO head to the write stage; wb_stall=1; no wb accept.
  2. Else, if wb_valid: pipeline write wins; FIFO head waits.
  3. Else, if FIFO is non-empty: pop head.
  4. Otherwise: rf_we=0 next cycle.
- FSM states:
  - IDLE: FIFO empty (after this cycle's push/pop).
  - DRAIN: FIFO non-empty.
  - FORCE: one-cycle forced grant. wb_stall is a decode of the FORCE state only.
- Starvation counter:
  - Increments each cycle the FIFO was non-empty and the head did not pop.
  - Clears on any pop, and whenever the FIFO is empty.
  - When the counter equals STARVE_LIMIT-1 and the head is blocked again: next state is FORCE, counter clears.
  - FORCE always exits after one cycle, to DRAIN or IDLE according to the post-pop occupancy.
- Simultaneous push and pop are permitted, including at full, since llu_ready is based on the start-of-cycle count. No push when full; LLU holds its result.
- Ordering: the FIFO is strictly in order, and the arbiter never reorders or merges writes. Decode must block issue of any instruction whose rd is set in pending_mask or is in flight in the LLU, so WAW between LLU and pipeline cannot occur. A duplicate rd therefore never occurs in normal operation; if it does, writes happen in grant order.
- pending_mask: OR of one-hot(rd) over valid FIFO entries, plus one-hot(rf_rd) when rf_we=1. Bit 0 is always 0. Combinational from registered state.
- fifo_count: wraps correctly with pointers of $clog2(DEPTH)+1 bits; full = count==DEPTH.
- Reset mid-operation: FIFO contents are discarded, any pending write is dropped, wb_stall deasserts immediately.

Optional Feature:
RF_ARB_STARVE_GUARD_EN
- Defined: starvation counter and FORCE state as above.
- Undefined: strict pipeline priority. The counter and FORCE state are removed and wb_stall is tied to 0. The LLU is served only in idle writeback cycles; STARVE_LIMIT is ignored.

Decomposition:
- Shared package rf_arb_pkg: state encoding (IDLE, DRAIN, FORCE), entry struct {rd[4:0], data[31:0]}, and the clog2-based count width helper.
- One sub-module, rf_arb_fifo: synchronous FIFO, DEPTH entries, push/pop/full/empty/count. It also exposes per-entry valid and rd to build pending_mask.
- Grant logic, FSM and write stage stay in the top.

Test Plan:
- Reset: with rst low, rf_we=0, wb_stall=0, llu_ready=1, pending_mask=0, fifo_count=0. Release rst and hold idle -> all outputs unchanged.
- Idle pipeline: LLU push rd=5, data=0xDEAD_BEEF at cycle t -> pending_mask bit5 set at t+1; rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF at t+2; pending_mask=0 at t+3.
- Fill: DEPTH=4 LLU pushes with wb_valid held 1 -> llu_ready=0 after the 4th, fifo_count=4. A 5th llu_valid is not accepted until a pop.
- Starvation (STARVE_LIMIT=8): FIFO holds rd=3 with wb_valid continuously 1 -> wb_stall=1 exactly one cycle after 8 blocked cycles; rd=3 written next cycle, then pipeline writes resume.
- Starvation guard compiled out: same stimulus -> wb_stall never asserts; rd=3 written on the first wb_valid=0 cycle.
- rd=0 handling: LLU rd=0 and wb rd=0 in the same cycle -> fifo_count unchanged, rf_we=0 next cycle.
- Async reset: rst asserted with 2 FIFO entries and FORCE active -> wb_stall=0 and fifo_count=0 without waiting for a clock edge; no write occurs after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM state encoding,
// the buffered LLU result entry, and the FIFO count width helper.
package rf_arb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } rf_entry_t;

    // Width of an occupancy count able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order FIFO for LLU results. No fall-through: a pushed entry is visible at
// the head one cycle later at the earliest. Pointers carry one extra wrap bit so
// full and empty are distinguished by the pointer difference alone. Per-entry
// valid flags and destinations are exported so the top can build the hazard mask.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  rf_entry_t                     push_entry,
    output rf_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_w(DEPTH)-1:0]       count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0] entry_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    rf_entry_t     mem_r [DEPTH];
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    assign count = PW'(wr_ptr_r - rd_ptr_r);
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == PW'(0));
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // Advance write and read pointers on accepted push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= PW'(wr_ptr_r + PW'(1));
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= PW'(rd_ptr_r + PW'(1));
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage; cleared on reset so stale destinations never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{rd: 5'd0, data: 32'd0};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_entry;
            end else begin
                mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
            end
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr_r[AW-1:0])} < count);
            entry_rd[i]    = mem_r[i].rd;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback normally
// owns the port; LLU results are buffered in rf_arb_fifo and written in cycles
// the pipeline leaves idle. All regfile writes pass through one registered stage.
// Build option RF_ARB_STARVE_GUARD_EN: when defined, a starvation counter forces
// a one-cycle FORCE grant (wb_stall=1) after STARVE_LIMIT blocked cycles; when
// undefined, the pipeline has strict priority and wb_stall is tied low.
module regfile_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    input  logic [4:0]              wb_rd,
    input  logic [31:0]             wb_data,
    output logic                    wb_stall,
    input  logic                    llu_valid,
    input  logic [4:0]              llu_rd,
    input  logic [31:0]             llu_data,
    output logic                    llu_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_rd,
    output logic [31:0]             rf_wdata,
    output logic [31:0]             pending_mask,
    output logic [cnt_w(DEPTH)-1:0] fifo_count
);

    localparam int CW = cnt_w(DEPTH);

    logic                           push_s;
    logic                           pop_s;
    logic                           force_s;
    logic                           fifo_full_s;
    logic                           fifo_empty_s;
    rf_entry_t                      push_entry_s;
    rf_entry_t                      head_s;
    logic [CW-1:0]                  count_s;
    logic [DEPTH-1:0]               entry_valid_s;
    logic [DEPTH-1:0][RF_ADDR_W-1:0] entry_rd_s;
    logic                           nxt_we_s;
    logic [4:0]                     nxt_rd_s;
    logic [31:0]                    nxt_data_s;
    logic                           rf_we_r;
    logic [4:0]                     rf_rd_r;
    logic [31:0]                    rf_wdata_r;
    logic [31:0]                    pend_s;

    // llu_ready comes from the start-of-cycle count; rd=0 results are acknowledged but dropped.
    assign llu_ready    = !fifo_full_s;
    assign push_s       = llu_valid && llu_ready && (llu_rd != 5'd0);
    assign push_entry_s = '{rd: llu_rd, data: llu_data};

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push        (push_s),
        .pop         (pop_s),
        .push_entry  (push_entry_s),
        .head        (head_s),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s),
        .count       (count_s),
        .entry_valid (entry_valid_s),
        .entry_rd    (entry_rd_s)
    );

    assign fifo_count = count_s;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    arb_state_e    state_r;
    logic [SW-1:0] starve_cnt_r;
    logic [CW-1:0] count_nxt_s;
    logic          head_blocked_s;

    assign force_s        = (state_r == ST_FORCE);
    assign wb_stall       = force_s;
    assign head_blocked_s = !fifo_empty_s && !pop_s;
    assign count_nxt_s    = CW'(count_s + CW'(push_s) - CW'(pop_s));

    // FSM and starvation counter: FORCE after STARVE_LIMIT consecutive blocked cycles, one cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= SW'(0);
        end else begin
            case (state_r)
                ST_FORCE: begin
                    starve_cnt_r <= SW'(0);
                    state_r      <= (count_nxt_s == CW'(0)) ? ST_IDLE : ST_DRAIN;
                end
                ST_IDLE, ST_DRAIN: begin
                    if (head_blocked_s && (starve_cnt_r == SW'(STARVE_LIMIT - 1))) begin
                        starve_cnt_r <= SW'(0);
                        state_r      <= ST_FORCE;
                    end else if (head_blocked_s) begin
                        starve_cnt_r <= SW'(starve_cnt_r + SW'(1));
                        state_r      <= ST_DRAIN;
                    end else begin
                        starve_cnt_r <= SW'(0);
                        state_r      <= (count_nxt_s == CW'(0)) ? ST_IDLE : ST_DRAIN;
                    end
                end
                default: begin
                    starve_cnt_r <= SW'(0);
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign force_s  = 1'b0;
    assign wb_stall = 1'b0;
`endif

    // Grant: forced drain, else pipeline writeback, else FIFO head, else nothing.
    always_comb begin
        pop_s      = 1'b0;
        nxt_we_s   = 1'b0;
        nxt_rd_s   = 5'd0;
        nxt_data_s = 32'd0;
        if (force_s) begin
            if (!fifo_empty_s) begin
                pop_s      = 1'b1;
                nxt_we_s   = 1'b1;
                nxt_rd_s   = head_s.rd;
                nxt_data_s = head_s.data;
            end else begin
                pop_s = 1'b0;
            end
        end else if (wb_valid) begin
            if (wb_rd != 5'd0) begin
                nxt_we_s   = 1'b1;
                nxt_rd_s   = wb_rd;
                nxt_data_s = wb_data;
            end else begin
                nxt_we_s = 1'b0;
            end
        end else if (!fifo_empty_s) begin
            pop_s      = 1'b1;
            nxt_we_s   = 1'b1;
            nxt_rd_s   = head_s.rd;
            nxt_data_s = head_s.data;
        end else begin
            nxt_we_s = 1'b0;
        end
    end

    // Registered write stage driving the regfile port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else begin
            rf_we_r    <= nxt_we_s;
            rf_rd_r    <= nxt_rd_s;
            rf_wdata_r <= nxt_data_s;
        end
    end

    assign rf_we    = rf_we_r;
    assign rf_rd    = rf_rd_r;
    assign rf_wdata = rf_wdata_r;

    // Pending destinations: live FIFO entries plus the write stage; r0 is never a hazard.
    always_comb begin
        pend_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_s[entry_rd_s[i]] = pend_s[entry_rd_s[i]] | entry_valid_s[i];
        end
        pend_s[rf_rd_r] = pend_s[rf_rd_r] | rf_we_r;
        pend_s[0]       = 1'b0;
    end

    assign pending_mask = pend_s;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: a queue-based reference model
// predicts each cycle's write and pushes it to a scoreboard; a vector table and
// hand-written sequences cover fill, starvation, rd=0 and async reset.
module tb_regfile_wr_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int CW           = $clog2(DEPTH) + 1;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int EXP_STALLS = 1;
    localparam int EXP_RD3_K  = 9;
    localparam int WB_HOLD    = 12;
`else
    localparam int EXP_STALLS = 0;
    localparam int EXP_RD3_K  = 11;
    localparam int WB_HOLD    = 11;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          wb_stall;
    logic          llu_valid;
    logic [4:0]    llu_rd;
    logic [31:0]   llu_data;
    logic          llu_ready;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [31:0]   rf_wdata;
    logic [31:0]   pending_mask;
    logic [CW-1:0] fifo_count;

    regfile_wr_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .llu_valid    (llu_valid),
        .llu_rd       (llu_rd),
        .llu_data     (llu_data),
        .llu_ready    (llu_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [4:0] rd; logic [31:0] data; } wr_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    typedef struct {
        logic wbv; logic [4:0] wbrd; logic [31:0] wbd;
        logic lv;  logic [4:0] lrd;  logic [31:0] ld;
        int exp_count; logic exp_we;
    } vec_t;

    wr_t  sb[$];
    ent_t mq[$];
    bit   m_force;
    int   m_cnt;
    wr_t  m_last;
    int   total;
    int   bad;
    vec_t vt[9];
    int   stall_n;
    int   first_stall;
    int   rd3_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        if (m_last.we) m[m_last.rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_force = 1'b0;
        m_cnt   = 0;
        m_last  = '{1'b0, 5'd0, 32'd0};
    endtask

    // Reference behaviour for one cycle, given this cycle's inputs.
    task automatic model_step(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        wr_t  w;
        ent_t e;
        int   start;
        bit   popped;
        start  = mq.size();
        popped = 1'b0;
        w      = '{1'b0, 5'd0, 32'd0};
        if (m_force) begin
            if (start > 0) begin
                e = mq.pop_front(); w = '{1'b1, e.rd, e.data}; popped = 1'b1;
            end
        end else if (wbv) begin
            if (wbrd != 5'd0) w = '{1'b1, wbrd, wbd};
        end else if (start > 0) begin
            e = mq.pop_front(); w = '{1'b1, e.rd, e.data}; popped = 1'b1;
        end
        if (lv && (start < DEPTH) && (lrd != 5'd0)) mq.push_back('{lrd, ld});
`ifdef RF_ARB_STARVE_GUARD_EN
        if (m_force) begin
            m_force = 1'b0; m_cnt = 0;
        end else if ((start > 0) && !popped) begin
            if (m_cnt == STARVE_LIMIT - 1) begin
                m_force = 1'b1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
`endif
        sb.push_back(w);
    endtask

    // Drive one cycle, advance the model, then compare every output after the edge.
    task automatic cycle(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        wr_t w;
        wb_valid  = wbv;  wb_rd  = wbrd; wb_data  = wbd;
        llu_valid = lv;   llu_rd = lrd;  llu_data = ld;
        model_step(wbv, wbrd, wbd, lv, lrd, ld);
        @(posedge clk);
        #1;
        w      = sb.pop_front();
        m_last = w;
        check("rf_we", rf_we, w.we);
        if (w.we) begin
            check("rf_rd", rf_rd, w.rd);
            check("rf_wdata", rf_wdata, w.data);
        end
        check("fifo_count", fifo_count, mq.size());
        check("llu_ready", llu_ready, (mq.size() < DEPTH));
        check("wb_stall", wb_stall, m_force);
        check("pending_mask", pending_mask, model_mask());
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        vt[0] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd5,  32'hDEADBEEF, 1, 1'b0};
        vt[1] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,        0, 1'b1};
        vt[2] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd9,  32'h22,       1, 1'b1};
        vt[3] = '{1'b1, 5'd8, 32'h33,       1'b1, 5'd10, 32'h44,       2, 1'b1};
        vt[4] = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0,  32'h66,       2, 1'b0};
        vt[5] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,        1, 1'b1};
        vt[6] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd11, 32'h77,       1, 1'b1};
        vt[7] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,        0, 1'b1};
        vt[8] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0,  32'd0,        0, 1'b0};

        // Reset state, before any clock edge and with edges under reset.
        rst = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        llu_valid = 1'b0; llu_rd = 5'd0; llu_data = 32'd0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_wb_stall", wb_stall, 1'b0);
        check("rst_llu_ready", llu_ready, 1'b1);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_count", fifo_count, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_edge_rf_we", rf_we, 1'b0);
        check("rst_edge_llu_ready", llu_ready, 1'b1);
        rst = 1'b1;
        repeat (3) idle();

        // Vector table: idle LLU write, pipeline priority, rd=0 on both sides, draining.
        for (int i = 0; i < 9; i++) begin
            cycle(vt[i].wbv, vt[i].wbrd, vt[i].wbd, vt[i].lv, vt[i].lrd, vt[i].ld);
            check($sformatf("vec%0d_count", i), fifo_count, vt[i].exp_count);
            check($sformatf("vec%0d_we", i), rf_we, vt[i].exp_we);
            if (i == 0) check("vec0_pend_bit5", pending_mask[5], 1'b1);
            if (i == 1) check("vec1_rd5_data", rf_wdata, 32'hDEADBEEF);
        end

        // Fill to DEPTH under continuous writeback; the 5th result waits for a pop.
        for (int k = 0; k < 13; k++) begin
            cycle((k < 6), 5'd21, 32'h0000_2121, (k < 8),
                  (k < 4) ? 5'(12 + k) : 5'd16,
                  (k < 4) ? 32'(32'h1200 + k) : 32'h0000_1616);
            if (k == 3 || k == 5) begin
                check($sformatf("fill%0d_count", k), fifo_count, 4);
                check($sformatf("fill%0d_ready", k), llu_ready, 1'b0);
            end
            if (k == 6) begin
                check("fill6_count", fifo_count, 3);
                check("fill6_ready", llu_ready, 1'b1);
            end
            if (k == 7) check("fill7_count", fifo_count, 3);
        end

        // Starvation: rd=3 buffered while writeback stays valid.
        stall_n = 0; first_stall = -1; rd3_k = -1;
        for (int k = 0; k < 12; k++) begin
            cycle((k < WB_HOLD), 5'd20, 32'hA5A5_0014, (k == 0), 5'd3, 32'h3333_3333);
            if (wb_stall) begin
                stall_n++;
                if (first_stall < 0) first_stall = k;
            end
            if (rf_we && (rf_rd == 5'd3) && (rd3_k < 0)) rd3_k = k;
        end
        check("starve_stall_cycles", stall_n, EXP_STALLS);
        check("starve_rd3_cycle", rd3_k, EXP_RD3_K);
`ifdef RF_ARB_STARVE_GUARD_EN
        check("starve_first_stall", first_stall, 8);
`endif
        repeat (2) idle();

        // Async reset with two buffered entries (and FORCE active when the guard is built).
        for (int k = 0; k < 9; k++) begin
            cycle(1'b1, 5'd22, 32'hC0DE_0016, (k < 2), (k == 0) ? 5'd3 : 5'd4, 32'(32'h3000 + k));
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        check("pre_reset_stall", wb_stall, 1'b1);
`endif
        check("pre_reset_count", fifo_count, 2);
        #2;
        rst = 1'b0;
        wb_valid = 1'b0; llu_valid = 1'b0;
        #1;
        check("async_wb_stall", wb_stall, 1'b0);
        check("async_count", fifo_count, 0);
        check("async_llu_ready", llu_ready, 1'b1);
        check("async_pending", pending_mask, 32'd0);
        check("async_rf_we", rf_we, 1'b0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
